contrast_auto_ctrl: RTL
=======================

# contrast_auto_ctrl

Closed-loop controller that drives the `inc`/`dec` inputs of the pixel contrast stage. It sits on the same RGB pixel stream as that stage, measures per-frame luma spread (max − min), and at each frame boundary issues at most one single-cycle `inc` or `dec` pulse to move the spread toward a target window. It keeps an internal mirror of the contrast level so that it never requests a step beyond 0 or 15.

## Interface
Parameters:
- TGT_LO, 8'd160, minimum acceptable spread; a smaller spread requests `inc`.
- TGT_HI, 8'd224, maximum acceptable spread; a larger spread requests `dec`. Must satisfy TGT_LO ≤ TGT_HI.
- HOLD_FRAMES, 2, number of frame boundaries after any pulse during which no new decision is made (range 0–15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  master enable.
- frame_en  in  1  single-cycle frame-boundary strobe.
- pix_valid  in  1  the R/G/B inputs carry an active pixel this cycle.
- R, G, B  in  8 each  pixel components.
- inc  out  1  one-cycle request to raise the contrast level by one step.
- dec  out  1  one-cycle request to lower the contrast level by one step.
- level_est  out  4  mirrored contrast level.
- stat_min, stat_max, stat_spread  out  8 each  statistics of the last completed frame (see Configuration).

## Operation
- Luma is computed as (R + 2G + B) >> 2, using a 10-bit sum truncated to 8 bits.
- Accumulator: `cur_min`, `cur_max` and `seen` update on every cycle where `pix_valid` is high.
  - On a `frame_en` cycle the accumulators restart. If `pix_valid` is also high, that pixel belongs to the new frame: min and max are both loaded with its luma and `seen` is set to 1. Otherwise min = 8'hFF, max = 0 and `seen` = 0.
- Snapshot: on a `frame_en` cycle, the old `cur_min`, `cur_max` and `seen` are copied into snapshot registers, and the FSM moves from IDLE to DECIDE.
- FSM states:
  - IDLE: waits for `frame_en`.
  - DECIDE: lasts one cycle. The spread is computed as snap_max − snap_min (8-bit; never negative because max ≥ min when `seen` is 1).
  - PULSE: lasts one cycle. The registered `inc` or `dec` is asserted. Then the FSM returns to IDLE.
- Decision rules, evaluated in DECIDE, in priority order:
  - If `seen` = 0 or `hold_cnt` ≠ 0, there is no pulse. `hold_cnt` is decremented (saturating at 0) and the FSM goes to IDLE.
  - Else if spread < TGT_LO and `level_est` < 15, assert `inc`.
  - Else if spread > TGT_HI and `level_est` > 0, assert `dec`.
  - Otherwise, no pulse.
- Pulse side effects: each pulse moves `level_est` by ±1 and loads `hold_cnt` with HOLD_FRAMES.
- `inc` and `dec` are never high together.
- A `frame_en` arriving in DECIDE or PULSE still restarts the accumulators and updates the snapshot, but no second decision is started. The FSM returns to IDLE.
- `enable` low:
  - FSM forced to IDLE.
  - `inc` and `dec` forced to 0.
  - Accumulators held in their restart state.
  - `level_est` and `hold_cnt` retained.

## Timing
- Reset values:
  - `inc` = `dec` = 0.
  - `level_est` = 4'h8, matching the contrast stage's reset level.
  - `hold_cnt` = 0.
  - FSM = IDLE.
  - `stat_*` = 0.
  - `cur_min` = 8'hFF, `cur_max` = 0, `seen` = 0.
- Latency: `frame_en` is high in cycle N, DECIDE is cycle N+1, and `inc`/`dec` is high for exactly cycle N+2. `level_est` reflects the new value from cycle N+3.
- The contrast stage steps once per cycle of `inc` assertion, so pulses must be exactly one cycle wide.
- `stat_*` registers update in cycle N+1.
- Reset mid-frame or mid-pulse: all state returns to reset values on the next edge, and any pulse in flight is dropped.
- Wrap: `level_est` never leaves the range 0–15. A request at a boundary produces no pulse.

## Configuration
- CONTRAST_AUTO_STATS_EN defined: `stat_min`, `stat_max` and `stat_spread` are registered copies of the snapshot min, max and spread, for debug and HEX display.
- CONTRAST_AUTO_STATS_EN not defined: the ports remain but are tied to 0, and their registers are not synthesized.
- Control behaviour is identical in both builds.

## Structure
- Shared package `contrast_pkg` holds:
  - LEVEL_RESET = 4'h8, LEVEL_MAX = 4'hF, LEVEL_MIN = 4'h0. The contrast stage should migrate to these.
  - The FSM state typedef {IDLE, DECIDE, PULSE}.
- One sub-module, `luma_minmax`, contains the luma computation plus the min/max/seen accumulator with the restart input. The top level contains the snapshot, FSM, hold counter and level mirror.

## Test plan
- Reset, then a frame of constant luma 100, then `frame_en` → spread 0 < 160, so `inc` is high for one cycle exactly 2 cycles after `frame_en`, and `level_est` becomes 9.
- A frame with pixel lumas 0 and 255 (spread 255) with `level_est` = 8 → one `dec`, and `level_est` becomes 7. Back-to-back identical frames with HOLD_FRAMES = 2 → the next two boundaries produce no pulse, and the third produces a `dec`.
- A frame with spread 200 → no pulse, `level_est` unchanged.
- Repeated low-spread frames with HOLD_FRAMES = 0 → `level_est` climbs to 15 and then stays there with no further `inc`.
- A frame with no `pix_valid` → no pulse. Also: `frame_en` coinciding with `pix_valid` of luma 50 → the next frame's min = max = 50.
- `rst` asserted in the PULSE cycle → `inc` deasserted on the next edge and `level_est` = 8. `enable` low for a frame → no pulses and `level_est` retained.

Source files
------------

// File: rtl/contrast_pkg.sv
// Shared constants, FSM state type and luma helper for the contrast stage and its auto controller.
package contrast_pkg;

    localparam logic [3:0] LEVEL_RESET = 4'h8;
    localparam logic [3:0] LEVEL_MAX   = 4'hF;
    localparam logic [3:0] LEVEL_MIN   = 4'h0;

    localparam logic [7:0] MIN_RESET   = 8'hFF;
    localparam logic [7:0] MAX_RESET   = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        DECIDE,
        PULSE
    } ctrl_state_t;

    // Luma approximation (R + 2G + B) / 4; the 10-bit sum cannot overflow.
    function automatic logic [7:0] calcLuma(input logic [7:0] r,
                                            input logic [7:0] g,
                                            input logic [7:0] b);
        logic [9:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[9:2];
    endfunction

endpackage

// File: rtl/luma_minmax.sv
// Per-frame luma min/max tracker; a restart strobe begins a new frame and may
// carry that frame's first pixel.
module luma_minmax
    import contrast_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_enable,
    input  logic       i_restart,
    input  logic       i_pixValid,
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
    output logic [7:0] o_curMin,
    output logic [7:0] o_curMax,
    output logic       o_seen
);

    logic [7:0] w_luma;
    logic [7:0] r_curMin;
    logic [7:0] r_curMax;
    logic       r_seen;

    assign w_luma = calcLuma(i_r, i_g, i_b);

    // While disabled the tracker sits in its restart state so a re-enable
    // never sees stale pixels.
    always_ff @(posedge clk) begin
        if (rst || !i_enable) begin
            r_curMin <= MIN_RESET;
            r_curMax <= MAX_RESET;
            r_seen   <= 1'b0;
        end else if (i_restart) begin
            if (i_pixValid) begin
                r_curMin <= w_luma;
                r_curMax <= w_luma;
                r_seen   <= 1'b1;
            end else begin
                r_curMin <= MIN_RESET;
                r_curMax <= MAX_RESET;
                r_seen   <= 1'b0;
            end
        end else if (i_pixValid) begin
            if (w_luma < r_curMin) begin
                r_curMin <= w_luma;
            end
            if (w_luma > r_curMax) begin
                r_curMax <= w_luma;
            end
            r_seen <= 1'b1;
        end
    end

    assign o_curMin = r_curMin;
    assign o_curMax = r_curMax;
    assign o_seen   = r_seen;

endmodule

// File: rtl/contrast_auto_ctrl.sv
// Closed-loop contrast controller: one inc/dec pulse per frame toward a luma-spread window.
// Define CONTRAST_AUTO_STATS_EN to register the last frame's min/max/spread on the stat ports.
module contrast_auto_ctrl
    import contrast_pkg::*;
#(
    parameter logic [7:0] TGT_LO      = 8'd160,
    parameter logic [7:0] TGT_HI      = 8'd224,
    parameter int         HOLD_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       frame_en,
    input  logic       pix_valid,
    input  logic [7:0] R,
    input  logic [7:0] G,
    input  logic [7:0] B,
    output logic       inc,
    output logic       dec,
    output logic [3:0] level_est,
    output logic [7:0] stat_min,
    output logic [7:0] stat_max,
    output logic [7:0] stat_spread
);

    logic [7:0]  w_curMin;
    logic [7:0]  w_curMax;
    logic        w_curSeen;
    logic [7:0]  w_spread;

    logic [7:0]  r_snapMin;
    logic [7:0]  r_snapMax;
    logic        r_snapSeen;

    ctrl_state_t r_state;
    logic        r_inc;
    logic        r_dec;
    logic [3:0]  r_level;
    logic [3:0]  r_holdCnt;

    luma_minmax u_lumaMinmax (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (enable),
        .i_restart  (frame_en),
        .i_pixValid (pix_valid),
        .i_r        (R),
        .i_g        (G),
        .i_b        (B),
        .o_curMin   (w_curMin),
        .o_curMax   (w_curMax),
        .o_seen     (w_curSeen)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snapMin  <= MIN_RESET;
            r_snapMax  <= MAX_RESET;
            r_snapSeen <= 1'b0;
        end else if (frame_en) begin
            r_snapMin  <= w_curMin;
            r_snapMax  <= w_curMax;
            r_snapSeen <= w_curSeen;
        end
    end

    assign w_spread = r_snapMax - r_snapMin;

    // The level mirror follows the pulse actually presented to the contrast
    // stage, so it is updated on the edge that ends PULSE even if enable drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_inc     <= 1'b0;
            r_dec     <= 1'b0;
            r_level   <= LEVEL_RESET;
            r_holdCnt <= 4'd0;
        end else begin
            if (r_inc && r_level != LEVEL_MAX) begin
                r_level <= r_level + 4'd1;
            end
            if (r_dec && r_level != LEVEL_MIN) begin
                r_level <= r_level - 4'd1;
            end
            if (r_inc || r_dec) begin
                r_holdCnt <= 4'(HOLD_FRAMES);
            end

            if (!enable) begin
                r_state <= IDLE;
                r_inc   <= 1'b0;
                r_dec   <= 1'b0;
            end else begin
                r_inc <= 1'b0;
                r_dec <= 1'b0;
                case (r_state)
                    IDLE: begin
                        if (frame_en) begin
                            r_state <= DECIDE;
                        end
                    end
                    DECIDE: begin
                        r_state <= IDLE;
                        // A new boundary arriving here abandons this decision.
                        if (!frame_en) begin
                            if (!r_snapSeen || r_holdCnt != 4'd0) begin
                                if (r_holdCnt != 4'd0) begin
                                    r_holdCnt <= r_holdCnt - 4'd1;
                                end
                            end else if (w_spread < TGT_LO && r_level != LEVEL_MAX) begin
                                r_inc   <= 1'b1;
                                r_state <= PULSE;
                            end else if (w_spread > TGT_HI && r_level != LEVEL_MIN) begin
                                r_dec   <= 1'b1;
                                r_state <= PULSE;
                            end
                        end
                    end
                    PULSE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign inc       = r_inc;
    assign dec       = r_dec;
    assign level_est = r_level;

`ifdef CONTRAST_AUTO_STATS_EN
    logic [7:0] r_statMin;
    logic [7:0] r_statMax;
    logic [7:0] r_statSpread;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_statMin    <= 8'd0;
            r_statMax    <= 8'd0;
            r_statSpread <= 8'd0;
        end else if (frame_en) begin
            r_statMin    <= w_curMin;
            r_statMax    <= w_curMax;
            r_statSpread <= w_curMax - w_curMin;
        end
    end

    assign stat_min    = r_statMin;
    assign stat_max    = r_statMax;
    assign stat_spread = r_statSpread;
`else
    assign stat_min    = 8'd0;
    assign stat_max    = 8'd0;
    assign stat_spread = 8'd0;
`endif

endmodule
